// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings, the PHT
// scheduler FSM state type and the update-queue entry layout.
// Queue entries carry a fixed-width index field wide enough for any table
// size in use; the scheduler zero-extends its INDEX_W-bit indices into it.
package bp_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] CNT_WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] CNT_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CNT_ST  = 2'b11;  // strongly taken

    localparam int unsigned PHT_INDEX_MAX_W = 16;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } pht_state_t;

    typedef struct packed {
        logic [PHT_INDEX_MAX_W-1:0] index;
        logic                       taken;
    } upd_entry_t;

endpackage

// File: rtl/counter_next_value.sv
// 2-bit saturating counter step (combinational).
// Ports:
//   cur_value  in  2 : current counter value
//   taken      in  1 : resolved outcome, 1 = increment, 0 = decrement
//   next_value out 2 : updated counter, saturating at CNT_ST / CNT_SNT
module counter_next_value
    import bp_pkg::*;
(
    input  logic [1:0] cur_value,
    input  logic       taken,
    output logic [1:0] next_value
);

    always_comb begin
        next_value = cur_value;
        if (taken) begin
            if (cur_value != CNT_ST) begin
                next_value = cur_value + 2'd1;
            end
        end else begin
            if (cur_value != CNT_SNT) begin
                next_value = cur_value - 2'd1;
            end
        end
    end

endmodule

// File: rtl/pht_update_scheduler.sv
// Pattern history table of 2-bit saturating counters with a scheduler that
// shares the single read port between fetch lookups and queued retire
// updates (drained as read/write two-stage read-modify-write operations).
// Optional build macro: PHT_LOOKUP_BYPASS_EN -- a lookup that coincides with
// a W-stage write to the same index returns the freshly written value.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   lookup_valid/index, lookup_ready : fetch-side lookup handshake
//   predict_valid/taken/counter    : registered lookup result (1-cycle latency)
//   update_valid/index/taken, update_ready : retire-side update handshake
//   init_busy                      : table initialisation sweep in progress
module pht_update_scheduler
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_W     = 6,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lookup_valid,
    input  logic [INDEX_W-1:0] lookup_index,
    output logic               lookup_ready,
    output logic               predict_valid,
    output logic               predict_taken,
    output logic [1:0]         predict_counter,
    input  logic               update_valid,
    input  logic [INDEX_W-1:0] update_index,
    input  logic               update_taken,
    output logic               update_ready,
    output logic               init_busy
);

    localparam int unsigned ENTRIES = 1 << INDEX_W;
    localparam int unsigned PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [INDEX_W-1:0] LAST_INDEX = '1;

    logic [1:0]         pht [ENTRIES];
    pht_state_t         state, state_next;
    logic [INDEX_W-1:0] sweep_idx;
    logic               run;

    upd_entry_t         queue [QUEUE_DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count;
    upd_entry_t         head_entry;
    logic               full, non_empty, push, pop, lookup_accept;

    logic                       w_valid;
    logic [PHT_INDEX_MAX_W-1:0] w_index;
    logic                       w_taken;
    logic [1:0]                 w_cur, w_next;
    logic [1:0]                 drain_cur, lookup_cur;

    // FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                sweep_idx <= sweep_idx + INDEX_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        init_busy  = 1'b0;
        run        = 1'b0;
        case (state)
            ST_INIT: begin
                init_busy = 1'b1;
                if (sweep_idx == LAST_INDEX) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN:  run = 1'b1;
            default: state_next = ST_INIT;
        endcase
    end

    // Arbitration: a full queue forces a drain; otherwise lookups have priority.
    assign full          = (count == FULL_COUNT);
    assign non_empty     = (count != '0);
    assign update_ready  = run && !full;
    assign lookup_ready  = run && !full;
    assign lookup_accept = lookup_ready && lookup_valid;
    assign push          = update_valid && update_ready;
    assign pop           = run && non_empty && (full || !lookup_valid);

    assign head_entry = queue[head];

    // R stage forwards the W result so back-to-back updates to one index chain.
    assign drain_cur = (w_valid && (w_index == head_entry.index))
                       ? w_next : pht[head_entry.index[INDEX_W-1:0]];

`ifdef PHT_LOOKUP_BYPASS_EN
    assign lookup_cur = (w_valid && (w_index == PHT_INDEX_MAX_W'(lookup_index)))
                        ? w_next : pht[lookup_index];
`else
    assign lookup_cur = pht[lookup_index];
`endif

    // Update queue
    always_ff @(posedge clk) begin
        if (push) begin
            queue[tail] <= '{index: PHT_INDEX_MAX_W'(update_index), taken: update_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // W stage
    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid <= 1'b0;
        end else begin
            w_valid <= pop;
        end
        if (pop) begin
            w_index <= head_entry.index;
            w_taken <= head_entry.taken;
            w_cur   <= drain_cur;
        end
    end

    counter_next_value u_counter_next_value (
        .cur_value  (w_cur),
        .taken      (w_taken),
        .next_value (w_next)
    );

    // Table writes: the init sweep or the W stage, never both (W is idle in INIT).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                pht[sweep_idx] <= CNT_WNT;
            end else if (w_valid) begin
                pht[w_index[INDEX_W-1:0]] <= w_next;
            end
        end
    end

    // Lookup result
    always_ff @(posedge clk) begin
        if (rst) begin
            predict_valid   <= 1'b0;
            predict_counter <= CNT_SNT;
        end else begin
            predict_valid <= lookup_accept;
            if (lookup_accept) begin
                predict_counter <= lookup_cur;
            end
        end
    end

    assign predict_taken = predict_counter[1];

endmodule

// File: doc/pht_update_scheduler.md
# pht_update_scheduler

Pattern history table (PHT) of 2-bit saturating branch counters, plus the scheduler that arbitrates the table's single read port between the fetch-side lookup stream and the retire-side update stream. Retire-side updates are buffered in a small queue and drained as read-modify-write operations through one `counter_next_value` instance. The block sits between the fetch predictor logic and the branch-resolution/retire logic.

## Interface
- `INDEX_W`, 6, table index width; the table holds 2^INDEX_W entries.
- `QUEUE_DEPTH`, 4, number of entries in the update queue (power of two, ≥2).
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, synchronous, active-high.
- `lookup_valid` in 1: a fetch-side prediction request is present.
- `lookup_index` in INDEX_W: PHT index of the lookup.
- `lookup_ready` out 1: the lookup is accepted this cycle.
- `predict_valid` out 1: prediction result is valid.
- `predict_taken` out 1: the counter's MSB.
- `predict_counter` out 2: full counter value.
- `update_valid` in 1: a branch resolution is present.
- `update_index` in INDEX_W: PHT index of the resolved branch.
- `update_taken` in 1: actual branch outcome (1 = taken).
- `update_ready` out 1: the update is accepted this cycle.
- `init_busy` out 1: table initialisation sweep is in progress.

## Operation
- FSM states:
  - INIT: an index counter walks 0..2^INDEX_W−1 and writes 2'b01 (weakly not-taken) to one entry per cycle. The FSM moves to RUN after the last index.
  - RUN: normal operation.
- In INIT, `init_busy`=1, `lookup_ready`=0 and `update_ready`=0.
- Update queue:
  - `update_ready` = RUN && count<QUEUE_DEPTH.
  - A push and a pop in the same cycle leave the count unchanged.
  - Entries drain in FIFO order.
- Read-port arbitration, evaluated each RUN cycle:
  - If count==QUEUE_DEPTH and the queue is non-empty: drain wins and `lookup_ready`=0.
  - Otherwise, if `lookup_valid`: lookup wins and `lookup_ready`=1; no drain occurs this cycle.
  - Otherwise, if the queue is non-empty: drain.
- Drain pipeline:
  - Cycle R: pop the head entry and read `table[idx]`.
  - Cycle W: `counter_next_value(cur, taken)` writes `table[idx]`.
  - Saturation: 11 with taken stays 11; 00 with not-taken stays 00; otherwise the counter moves ±1.
- Write-to-read forwarding between drains (mandatory): if drain R reads the same index that the W stage is writing this cycle, it uses the W result instead of the table. This keeps back-to-back updates to one index cumulative.
- Lookup: the table is read in the accept cycle, and the registered result is presented one cycle later.
- `rst` (at any time, including mid-drain or mid-INIT):
  - Flushes the queue and the W stage.
  - Clears `predict_valid`.
  - Restarts INIT at index 0.
  - In-flight updates are lost.

## Timing
- Reset values:
  - `lookup_ready`=0, `update_ready`=0, `init_busy`=1.
  - `predict_valid`=0, `predict_taken`=0, `predict_counter`=2'b00.
  - Queue count=0; FSM=INIT, sweep index=0.
- INIT takes exactly 2^INDEX_W cycles after `rst` deasserts. `update_ready`/`lookup_ready` may assert on the next cycle.
- Lookup latency is 1 cycle: accept at cycle T gives `predict_valid` at T+1, which holds for one cycle only.
- Update visibility:
  - Enqueue at T → earliest R stage at T+1 → table written at the end of T+2.
  - A lookup at T+3 sees the new value.
- Throughput: one drain per cycle when there is no lookup.

## Configuration
- `PHT_LOOKUP_BYPASS_EN`
  - Defined: a lookup accepted in the same cycle as a W-stage write to the same index returns the newly written value.
  - Undefined: that lookup returns the pre-write table value, and the update becomes visible one cycle later.
- Drain-to-drain forwarding is present in both builds.

## Structure
- Shared package `bp_pkg`:
  - Counter encoding constants: `CNT_SNT`=2'b00, `CNT_WNT`=2'b01, `CNT_WT`=2'b10, `CNT_ST`=2'b11.
  - INIT/RUN state typedef.
  - Update-queue entry struct {index, taken}.
- One sub-module: `counter_next_value` (2-bit saturating increment/decrement, combinational), instantiated once in the W stage.
- Queue is inline registers with head/tail pointers; no separate FIFO module.

## Test plan
- Reset, INDEX_W=6 → `init_busy` high for 64 cycles. After INIT, a lookup of index 0 and a lookup of index 63 each return counter 01, `predict_taken`=0.
- Four back-to-back taken updates to index 5, no lookups, then a lookup of index 5 → counter 11, taken=1. Next, four not-taken updates → counter 00.
- Hold `lookup_valid`=1 continuously while pushing 4 updates → queue fills. `lookup_ready` drops to 0 for one cycle while one entry drains, and `update_ready`=0 while full.
- Update taken to index 9 (counter 01). Time a lookup of index 9 in the W cycle:
  - With `PHT_LOOKUP_BYPASS_EN` → 10.
  - Without it → 01, and a lookup one cycle later → 10.
- Assert `rst` with 3 queued updates and a drain in the W stage → queue empty, `predict_valid`=0, and INIT restarts. After INIT, the touched indices read 01.
- Simultaneous push and pop at count 3 → count stays 3, `update_ready` stays 1, and FIFO order is preserved.
